// File: rtl/fde_pipe_regs_pkg.sv
// Shared y86 definitions: instruction codes, register IDs, one-hot status and
// the packed D/E register layouts with their bubble values.
package y86_pkg;

  typedef logic [0:3] nib_t;

  localparam nib_t IHALT   = 4'h0;
  localparam nib_t INOP    = 4'h1;
  localparam nib_t IRRMOVQ = 4'h2;
  localparam nib_t IIRMOVQ = 4'h3;
  localparam nib_t IRMMOVQ = 4'h4;
  localparam nib_t IMRMOVQ = 4'h5;
  localparam nib_t IOPQ    = 4'h6;
  localparam nib_t IJXX    = 4'h7;
  localparam nib_t ICALL   = 4'h8;
  localparam nib_t IRET    = 4'h9;
  localparam nib_t IPUSHQ  = 4'hA;
  localparam nib_t IPOPQ   = 4'hB;

  localparam nib_t RNONE = 4'hF;

  // Index 0 of a [0:3] status is AOK, so it is the leftmost literal bit.
  localparam nib_t SAOK = 4'b1000;
  localparam nib_t SHLT = 4'b0100;
  localparam nib_t SADR = 4'b0010;
  localparam nib_t SINS = 4'b0001;

  typedef struct packed {
    nib_t        stat;
    nib_t        icode;
    nib_t        ifun;
    nib_t        ra;
    nib_t        rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } d_reg_t;

  typedef struct packed {
    nib_t        stat;
    nib_t        icode;
    nib_t        ifun;
    nib_t        dste;
    nib_t        dstm;
    nib_t        srca;
    nib_t        srcb;
    logic [63:0] vala;
    logic [63:0] valb;
    logic [63:0] valc;
  } e_reg_t;

  localparam d_reg_t D_BUBBLE = '{stat: SAOK, icode: INOP, ifun: 4'h0,
                                  ra: RNONE, rb: RNONE,
                                  valc: 64'h0, valp: 64'h0};

  localparam e_reg_t E_BUBBLE = '{stat: SAOK, icode: INOP, ifun: 4'h0,
                                  dste: RNONE, dstm: RNONE,
                                  srca: RNONE, srcb: RNONE,
                                  vala: 64'h0, valb: 64'h0, valc: 64'h0};

endpackage

// File: rtl/fde_pipe_regs_if.sv
// Fetch/decode datapath inputs, pipeline controls and F/D/E register outputs.
interface fde_pipe_regs_if;
  import y86_pkg::*;

  logic        F_stall;
  logic        D_stall;
  logic        D_bubble;
  logic        E_bubble;

  logic [63:0] f_predPC;
  nib_t        f_stat, f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP;

  nib_t        d_stat, d_icode, d_ifun;
  logic [63:0] d_valA, d_valB, d_valC;
  nib_t        d_dstE, d_dstM, d_srcA, d_srcB;

  logic [63:0] F_predPC;
  nib_t        D_stat, D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  nib_t        E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valA, E_valB, E_valC;

  modport master (
    output F_stall, D_stall, D_bubble, E_bubble,
    output f_predPC, f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
    output d_stat, d_icode, d_ifun, d_valA, d_valB, d_valC,
    output d_dstE, d_dstM, d_srcA, d_srcB,
    input  F_predPC, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
    input  E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB,
    input  E_valA, E_valB, E_valC
  );

  modport slave (
    input  F_stall, D_stall, D_bubble, E_bubble,
    input  f_predPC, f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
    input  d_stat, d_icode, d_ifun, d_valA, d_valB, d_valC,
    input  d_dstE, d_dstM, d_srcA, d_srcB,
    output F_predPC, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
    output E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB,
    output E_valA, E_valB, E_valC
  );

endinterface

// File: rtl/fde_pipe_regs_pipe_reg.sv
// Generic pipeline register: reset and bubble load bubble_val, stall holds and
// takes priority over bubble.
module pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             bubble,
  input  logic [WIDTH-1:0] bubble_val,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (!stall) begin
      if (bubble) data_d = bubble_val;
      else        data_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) data_q <= bubble_val;
    else       data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/fde_pipe_regs.sv
// F, D and E pipeline registers of the pipelined y86 core, plus stall/bubble
// counters and a sticky flag for the illegal D_stall+D_bubble combination.
module fde_pipe_regs
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  fde_pipe_regs_if.slave    pif,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic              ctl_conflict
);

  d_reg_t      d_in, d_out;
  e_reg_t      e_in, e_out;
  logic [63:0] f_out;

  always_comb begin
    d_in       = D_BUBBLE;
    d_in.stat  = pif.f_stat;
    d_in.icode = pif.f_icode;
    d_in.ifun  = pif.f_ifun;
    d_in.ra    = pif.f_rA;
    d_in.rb    = pif.f_rB;
    d_in.valc  = pif.f_valC;
    d_in.valp  = pif.f_valP;

    e_in       = E_BUBBLE;
    e_in.stat  = pif.d_stat;
    e_in.icode = pif.d_icode;
    e_in.ifun  = pif.d_ifun;
    e_in.dste  = pif.d_dstE;
    e_in.dstm  = pif.d_dstM;
    e_in.srca  = pif.d_srcA;
    e_in.srcb  = pif.d_srcB;
    e_in.vala  = pif.d_valA;
    e_in.valb  = pif.d_valB;
    e_in.valc  = pif.d_valC;
  end

  // F never bubbles; its "bubble value" doubles as the reset PC.
  pipe_reg #(.WIDTH(64)) u_f_reg (
    .clk, .reset,
    .stall(pif.F_stall), .bubble(1'b0),
    .bubble_val(RESET_PC), .din(pif.f_predPC), .q(f_out)
  );

  pipe_reg #(.WIDTH($bits(d_reg_t))) u_d_reg (
    .clk, .reset,
    .stall(pif.D_stall), .bubble(pif.D_bubble),
    .bubble_val(D_BUBBLE), .din(d_in), .q(d_out)
  );

  pipe_reg #(.WIDTH($bits(e_reg_t))) u_e_reg (
    .clk, .reset,
    .stall(1'b0), .bubble(pif.E_bubble),
    .bubble_val(E_BUBBLE), .din(e_in), .q(e_out)
  );

  assign pif.F_predPC = f_out;
  assign pif.D_stat   = d_out.stat;
  assign pif.D_icode  = d_out.icode;
  assign pif.D_ifun   = d_out.ifun;
  assign pif.D_rA     = d_out.ra;
  assign pif.D_rB     = d_out.rb;
  assign pif.D_valC   = d_out.valc;
  assign pif.D_valP   = d_out.valp;
  assign pif.E_stat   = e_out.stat;
  assign pif.E_icode  = e_out.icode;
  assign pif.E_ifun   = e_out.ifun;
  assign pif.E_dstE   = e_out.dste;
  assign pif.E_dstM   = e_out.dstm;
  assign pif.E_srcA   = e_out.srca;
  assign pif.E_srcB   = e_out.srcb;
  assign pif.E_valA   = e_out.vala;
  assign pif.E_valB   = e_out.valb;
  assign pif.E_valC   = e_out.valc;

  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
  logic             ctl_conflict_d, ctl_conflict_q;

  always_comb begin
    stall_cnt_d    = stall_cnt_q;
    bubble_cnt_d   = bubble_cnt_q;
    ctl_conflict_d = ctl_conflict_q;
    if (pif.D_stall)                  stall_cnt_d  = stall_cnt_q + CNT_W'(1);
    if (pif.D_bubble || pif.E_bubble) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    if (pif.D_stall && pif.D_bubble)  ctl_conflict_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q    <= '0;
      bubble_cnt_q   <= '0;
      ctl_conflict_q <= 1'b0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      bubble_cnt_q   <= bubble_cnt_d;
      ctl_conflict_q <= ctl_conflict_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign bubble_cnt   = bubble_cnt_q;
  assign ctl_conflict = ctl_conflict_q;

endmodule
